regfile_write_sched: RTL



---
 rtl/regfile_pkg.sv | 14 +
 rtl/rr_arb2.sv | 38 +++
 rtl/regfile_write_sched.sv | 85 ++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and port identifiers for the register-file write scheduler.
package regfile_pkg;

    localparam int unsigned NREGS = 8;
    localparam int unsigned AW    = 3;
    localparam int unsigned DW    = 8;

    // Identifies a write producer; used for the round-robin priority and grants.
    typedef enum logic {
        PORT_ALU = 1'b0,
        PORT_MEM = 1'b1
    } port_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin arbiter; the priority pointer moves to the loser after every grant.
module rr_arb2
    import regfile_pkg::*;
(
    input  logic       CLK,
    input  logic       RESET,
    input  logic [1:0] req,
    output logic [1:0] gnt_c
);

    port_t prio;
    port_t prio_next;

    // Grant selection and next priority
    always_comb begin
        gnt_c     = 2'b00;
        prio_next = prio;
        if (req == 2'b11) begin
            gnt_c = (prio == PORT_ALU) ? 2'b01 : 2'b10;
        end else begin
            gnt_c = req;
        end
        if (gnt_c[0]) begin
            prio_next = PORT_MEM;
        end else if (gnt_c[1]) begin
            prio_next = PORT_ALU;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            prio <= PORT_ALU;
        end else begin
            prio <= prio_next;
        end
    end

endmodule

// File: rtl/regfile_write_sched.sv
// Shares the register file write port between ALU writeback and load return,
// and tracks pending writes per register in a busy scoreboard.
module regfile_write_sched
    import regfile_pkg::*;
#(
    parameter int unsigned NREGS = regfile_pkg::NREGS,
    parameter int unsigned AW    = regfile_pkg::AW,
    parameter int unsigned DW    = regfile_pkg::DW
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             ALU_VALID,
    input  logic [AW-1:0]    ALU_ADDR,
    input  logic [DW-1:0]    ALU_DATA,
    output logic             ALU_READY,
    input  logic             MEM_VALID,
    input  logic [AW-1:0]    MEM_ADDR,
    input  logic [DW-1:0]    MEM_DATA,
    output logic             MEM_READY,
    input  logic             RSV_VALID,
    input  logic [AW-1:0]    RSV_ADDR,
    output logic             WRITE,
    output logic [AW-1:0]    INADDRESS,
    output logic [DW-1:0]    INDATA,
    output logic [NREGS-1:0] BUSY,
    output logic             ERR
);

    logic [1:0]       gnt_c;
    logic             acc_c;
    logic [AW-1:0]    wr_addr_c;
    logic [DW-1:0]    wr_data_c;
    logic [NREGS-1:0] clr_c;
    logic [NREGS-1:0] set_c;
    logic             err_c;

    rr_arb2 u_arb (
        .CLK   (CLK),
        .RESET (RESET),
        .req   ({MEM_VALID, ALU_VALID}),
        .gnt_c (gnt_c)
    );

    assign ALU_READY = gnt_c[0] && !RESET;
    assign MEM_READY = gnt_c[1] && !RESET;

    // Winning write, scoreboard updates and protocol checks
    always_comb begin
        acc_c     = ALU_READY || MEM_READY;
        wr_addr_c = MEM_READY ? MEM_ADDR : ALU_ADDR;
        wr_data_c = MEM_READY ? MEM_DATA : ALU_DATA;
        clr_c     = '0;
        set_c     = '0;
        if (acc_c) begin
            clr_c = NREGS'(1) << wr_addr_c;
        end
        if (RSV_VALID) begin
            set_c = NREGS'(1) << RSV_ADDR;
        end
        err_c = (RSV_VALID && BUSY[RSV_ADDR] && !clr_c[RSV_ADDR]) ||
                (acc_c && !BUSY[wr_addr_c]);
    end

    // Set is applied after clear so a same-cycle reservation keeps the bit busy.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            WRITE     <= 1'b0;
            INADDRESS <= '0;
            INDATA    <= '0;
            BUSY      <= '0;
            ERR       <= 1'b0;
        end else begin
            WRITE <= acc_c;
            if (acc_c) begin
                INADDRESS <= wr_addr_c;
                INDATA    <= wr_data_c;
            end
            BUSY <= (BUSY & ~clr_c) | set_c;
            if (err_c) begin
                ERR <= 1'b1;
            end
        end
    end

endmodule
